// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared helpers for sfifo_param (width derivation, threshold defaults).
package sfifo_pkg;
    localparam int AEMPTY_DEFAULT = 8;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction
    function automatic int afull_default(input int depth);
        return depth - 8;
    endfunction
endpackage

// File: rtl/sfifo_ram.sv
// sfifo_ram: single-clock simple dual-port RAM with registered, resettable read data.
module sfifo_ram #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    always_comb rdata_d = re ? mem[raddr] : rdata_q;
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    always_ff @(posedge clk) rdata_q <= rst ? '0 : rdata_d;
    assign rdata = rdata_q;
endmodule

// File: rtl/sfifo_param.sv
// sfifo_param: parametrised single-clock FIFO with count, threshold flags and overflow/underflow pulses.
// Define SFIFO_FWFT_EN for first-word-fall-through mode (RAM read register acts as the prefetch stage).
module sfifo_param import sfifo_pkg::*; #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDRESS_WIDTH = 12,
    parameter int AFULL_THRESH = afull_default(2**ADDRESS_WIDTH),
    parameter int AEMPTY_THRESH = AEMPTY_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  din,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [ADDRESS_WIDTH:0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int DEPTH = 2**ADDRESS_WIDTH;
    localparam int CW = cnt_w(DEPTH);
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic wr_acc, rd_acc, ram_re;
`ifdef SFIFO_FWFT_EN
    logic ov_q, ov_d;
`endif
    always_comb begin
        wr_acc = wr_en & ~full_q;
        rd_acc = rd_en & ~empty_q;
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
`ifdef SFIFO_FWFT_EN
        // prefetch whenever the output slot is free or being popped and RAM still holds words
        ram_re = (~ov_q | rd_acc) & (count_q != CW'(ov_q));
        ov_d = ram_re | (ov_q & ~rd_acc);
        empty_d = ~ov_d;
`else
        ram_re = rd_acc;
        empty_d = count_d == '0;
`endif
        wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(wr_acc);
        rd_ptr_d = rd_ptr_q + ADDRESS_WIDTH'(ram_re);
        full_d = count_d == CW'(DEPTH);
        afull_d = count_d >= CW'(AFULL_THRESH);
        aempty_d = count_d <= CW'(AEMPTY_THRESH);
        ovf_d = wr_en & full_q;
        unf_d = rd_en & empty_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
`ifdef SFIFO_FWFT_EN
            ov_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
`ifdef SFIFO_FWFT_EN
            ov_q     <= ov_d;
`endif
        end
    end
    sfifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_ram (
        .clk(clk),
        .rst(rst),
        .we(wr_acc),
        .waddr(wr_ptr_q),
        .wdata(din),
        .re(ram_re),
        .raddr(rd_ptr_q),
        .rdata(dout)
    );
    assign full = full_q;
    assign empty = empty_q;
    assign almost_full = afull_q;
    assign almost_empty = aempty_q;
    assign count = count_q;
    assign overflow = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param: directed self-checking bench for sfifo_param (8-bit x 8 deep, afull 6, aempty 1).
module tb_sfifo_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] din = '0;
    logic wr_en = 1'b0;
    logic rd_en = 1'b0;
    logic [7:0] dout;
    logic full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;
    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;
    sfifo_param #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3), .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_count", count, 0);
        chk("rst_dout", dout, 0);
`ifdef SFIFO_FWFT_EN
        din = 8'hA5;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("fwft_lat1_empty", empty, 1);
        chk("fwft_lat1_count", count, 1);
        tick();
        chk("fwft_lat2_empty", empty, 0);
        chk("fwft_lat2_dout", dout, 8'hA5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("fwft_pop_empty", empty, 1);
        chk("fwft_pop_count", count, 0);
        for (int i = 1; i <= 3; i++) begin
            din = 8'hB0 + 8'(i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("fwft_head", dout, 8'hB1);
        chk("fwft_cnt3", count, 3);
        rd_en = 1'b1;
        for (int i = 2; i <= 3; i++) begin
            tick();
            chk("fwft_seq", dout, 8'hB0 + 32'(i));
            chk("fwft_seq_cnt", count, 32'(4 - i));
        end
        tick();
        chk("fwft_last_empty", empty, 1);
        tick();
        rd_en = 1'b0;
        chk("fwft_underflow", underflow, 1);
`else
        for (int i = 1; i <= 8; i++) begin
            din = 8'(8'h11 * i);
            wr_en = 1'b1;
            tick();
            chk("fill_count", count, 32'(i));
            chk("fill_aempty", almost_empty, 32'(i <= 1));
            chk("fill_afull", almost_full, 32'(i >= 6));
            chk("fill_full", full, 32'(i == 8));
        end
        din = 8'h99;
        tick();
        wr_en = 1'b0;
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 8);
        tick();
        chk("ovf_clear", overflow, 0);
        rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("drain_dout", dout, 32'(8'h11 * i));
            chk("drain_count", count, 32'(8 - i));
        end
        chk("drain_empty", empty, 1);
        tick();
        rd_en = 1'b0;
        chk("unf_pulse", underflow, 1);
        chk("unf_dout_hold", dout, 8'h88);
        tick();
        chk("unf_clear", underflow, 0);
        din = 8'h5A;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("wr_on_empty_count", count, 1);
        chk("wr_on_empty_unf", underflow, 1);
        chk("wr_on_empty_dout", dout, 8'h88);
        q.push_back(8'h5A);
        for (int i = 1; i <= 3; i++) begin
            din = 8'(i);
            wr_en = 1'b1;
            q.push_back(din);
            tick();
        end
        chk("pre_stream_count", count, 4);
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din = 8'h10 + 8'(k);
            exp_d = q.pop_front();
            q.push_back(din);
            tick();
            chk("stream_dout", dout, exp_d);
            chk("stream_count", count, 4);
        end
        rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = 8'hC0 + 8'(i);
            q.push_back(din);
            tick();
        end
        chk("refill_full", full, 1);
        din = 8'hEE;
        rd_en = 1'b1;
        exp_d = q.pop_front();
        tick();
        wr_en = 1'b0;
        chk("full_rw_ovf", overflow, 1);
        chk("full_rw_count", count, 7);
        chk("full_rw_dout", dout, exp_d);
        chk("full_rw_full", full, 0);
        for (int i = 0; i < 2; i++) begin
            exp_d = q.pop_front();
            tick();
            chk("pre_rst_dout", dout, exp_d);
        end
        rd_en = 1'b0;
        chk("pre_rst_count", count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_aempty", almost_empty, 1);
        din = 8'h77;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("post_rst_write", count, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("post_rst_read", dout, 8'h77);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sfifo_param.md
Name: sfifo_param

Overview:
- Parametrised single-clock FIFO; successor to the fixed 72-bit dual-clock FIFO wrappers in the PCIe DMA datapath.
- Adds configurable depth, programmable almost-full and almost-empty thresholds, an occupancy count, and overflow/underflow pulses.
- Used wherever producer and consumer share one clock, e.g. TLP staging inside the 250 MHz user domain.

Parameters:
- DATA_WIDTH, 72, word width in bits.
- ADDRESS_WIDTH, 12, log2 of storage depth; DEPTH = 2**ADDRESS_WIDTH.
- AFULL_THRESH, DEPTH-8, almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 8, almost_empty asserts when count <= AEMPTY_THRESH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (FWFT: acknowledge of the head word).
- dout  out  DATA_WIDTH  read data.
- full  out  1  no write accepted this cycle.
- empty  out  1  no read accepted this cycle.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- count  out  ADDRESS_WIDTH+1  words held, 0..DEPTH.
- overflow  out  1  one-cycle pulse: wr_en while full.
- underflow  out  1  one-cycle pulse: rd_en while empty.

Behaviour:
- Reset state: pointers 0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, dout=0, overflow=0, underflow=0.
- Reset mid-operation discards all contents. The first cycle after rst deasserts may accept a write.
- Write accepted = wr_en & ~full. Stores din at wr_ptr, then wr_ptr increments modulo DEPTH.
- Read accepted = rd_en & ~empty. dout is registered and carries the word one cycle after the accepted read. dout holds its value otherwise.
- full and empty are the registered values at the start of the cycle. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: count unchanged; both pointers advance.
- count_next = count + wr_acc - rd_acc.
- All flags are registered from count_next: full = (count_next == DEPTH), empty = (count_next == 0), plus the two thresholds. Flags therefore have zero-cycle lag relative to count.
- Pointers are ADDRESS_WIDTH bits and wrap naturally. count is the authority for full and empty.
- overflow and underflow are registered one cycle after the offending request. Rejected requests change no state.
- Storage: simple dual-port RAM with write-first-irrelevant semantics. Read and write never target the same address in the same cycle unless count==0, and that read is rejected.

Optional Feature:
- Macro: SFIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - The head word is presented on dout with empty=0 without any rd_en; rd_en pops it.
  - An internal output register prefetches from RAM. Latency from a write into an empty FIFO to empty=0 is 2 cycles.
  - count includes the output-register word; full still asserts at count == DEPTH.
- Undefined: standard mode as above, with 1-cycle read latency.

Decomposition:
- Package sfifo_pkg holds:
  - a clog2 function;
  - the count-width derivation;
  - the threshold defaults expressed relative to DEPTH.
- One sub-module: sfifo_ram, a single-clock simple dual-port RAM with registered read, parameters DATA_WIDTH/ADDRESS_WIDTH.
- Pointer, count and flag logic stays in sfifo_param.

Test Plan (DATA_WIDTH=8, ADDRESS_WIDTH=3, AFULL_THRESH=6, AEMPTY_THRESH=1):
1. Reset → empty=1, almost_empty=1, full=0, count=0, dout=0. Write 0x11..0x88 on 8 consecutive cycles → count steps 1..8; almost_empty drops after the 2nd write; almost_full rises after the 6th; full=1 after the 8th.
2. Full FIFO, wr_en=1 with din=0x99 → overflow pulses 1 cycle, count stays 8. Then 8 reads → dout 0x11..0x88 in order, 1 cycle after each rd_en.
3. Empty FIFO, rd_en=1 → underflow pulse, dout unchanged. Simultaneous wr_en(0x5A) and rd_en on empty → write accepted, read rejected, count=1.
4. count=4, wr_en and rd_en held together for 20 cycles with an incrementing pattern → count constant 4; pointers wrap; data order preserved.
5. Full FIFO, simultaneous rd_en and wr_en → read accepted, write rejected, overflow=1, count=7. Assert rst with count=5 → next cycle count=0, empty=1, dout=0.
6. SFIFO_FWFT_EN defined: write 0xA5 to an empty FIFO → empty=0 and dout=0xA5 two cycles later with no rd_en; rd_en for one cycle → empty=1, count=0.
